// File: rtl/cluster_seq_pkg.sv
// Shared types and constants for the cluster sequencer and its result drain.
// Holds the FSM state enum, lane/tap counts and default width parameters.
package cluster_seq_pkg;

  localparam int NUM_LANES   = 6;
  localparam int FILTER_TAPS = 3;
  localparam int LANE_W      = 3;

  localparam int DEF_IN_WIDTH       = 5;
  localparam int DEF_W_WIDTH        = 8;
  localparam int DEF_ACC_WIDTH      = 16;
  localparam int DEF_TILE_W         = 8;
  localparam int DEF_TIMEOUT_CYCLES = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // Lane index after an accepted beat; wraps so the next tile starts at lane 0.
  function automatic logic [LANE_W-1:0] next_lane(input logic [LANE_W-1:0] lane);
    return (lane == LANE_W'(NUM_LANES - 1)) ? '0 : lane + LANE_W'(1);
  endfunction

endpackage

// File: rtl/cluster_result_drain.sv
// Lane serialiser: captures all cluster results at once, then presents them
// one lane at a time (0..5) under a valid/ready handshake.
module cluster_result_drain
  import cluster_seq_pkg::*;
#(
  parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_capture,
  input  logic [NUM_LANES*ACC_WIDTH-1:0] i_cl_out,
  input  logic                           i_active,
  input  logic                           i_res_ready,
  output logic                           o_res_valid,
  output logic [ACC_WIDTH-1:0]           o_res_data,
  output logic [LANE_W-1:0]              o_res_lane,
  output logic                           o_last_accept
);

  logic [NUM_LANES*ACC_WIDTH-1:0] r_result;
  logic [LANE_W-1:0]              r_lane;
  logic                           w_accept;

  assign w_accept      = i_active & i_res_ready;
  assign o_res_valid   = i_active;
  assign o_res_data    = r_result[r_lane*ACC_WIDTH +: ACC_WIDTH];
  assign o_res_lane    = r_lane;
  assign o_last_accept = w_accept && (r_lane == LANE_W'(NUM_LANES - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and the block order never matters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_lane   <= '0;
    end else if (i_capture) begin
      r_result <= i_cl_out;
      r_lane   <= '0;
    end else if (w_accept) begin
      r_lane <= next_lane(r_lane);
    end
  end

endmodule

// File: rtl/cluster_sequencer.sv
// Job sequencer: fetches tile operands, starts the compute cluster, and drains
// six lane results per tile. Optional WAIT watchdog: CLUSTER_SEQ_TIMEOUT_EN.
module cluster_sequencer
  import cluster_seq_pkg::*;
#(
  parameter int IN_WIDTH       = DEF_IN_WIDTH,
  parameter int W_WIDTH        = DEF_W_WIDTH,
  parameter int ACC_WIDTH      = DEF_ACC_WIDTH,
  parameter int TILE_W         = DEF_TILE_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             job_valid,
  output logic                             job_ready,
  input  logic [TILE_W-1:0]                job_tiles,
  output logic                             rd_en,
  output logic [TILE_W-1:0]                rd_addr,
  input  logic                             rd_valid,
  input  logic [NUM_LANES*IN_WIDTH-1:0]    rd_data,
  input  logic [FILTER_TAPS*W_WIDTH-1:0]   rd_filter,
  output logic                             cl_start,
  output logic [NUM_LANES*IN_WIDTH-1:0]    cl_data,
  output logic [FILTER_TAPS*W_WIDTH-1:0]   cl_filter,
  input  logic [NUM_LANES-1:0]             cl_finished,
  input  logic [NUM_LANES*ACC_WIDTH-1:0]   cl_out,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic [ACC_WIDTH-1:0]             res_data,
  output logic [LANE_W-1:0]                res_lane,
  output logic [TILE_W-1:0]                res_tile,
  output logic                             busy,
  output logic                             done,
  output logic                             err
);

  state_e                          r_state;
  state_e                          w_next;
  logic [TILE_W-1:0]               r_tile;
  logic [TILE_W-1:0]               r_tiles;
  logic [NUM_LANES*IN_WIDTH-1:0]   r_cl_data;
  logic [FILTER_TAPS*W_WIDTH-1:0]  r_cl_filter;
  logic                            w_accept_job;
  logic                            w_capture;
  logic                            w_drain_active;
  logic                            w_drain_last;
  logic                            w_last_tile;
  logic                            w_timeout;

  assign w_accept_job   = job_valid && (r_state == ST_IDLE);
  assign w_capture      = (r_state == ST_WAIT) && (|cl_finished);
  assign w_drain_active = (r_state == ST_DRAIN);
  assign w_last_tile    = (r_tile == r_tiles - TILE_W'(1));

`ifdef CLUSTER_SEQ_TIMEOUT_EN
  localparam int WCNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WCNT_W-1:0] r_wait_cnt;
  logic              r_err;

  // Fires on the last permitted WAIT cycle, so WAIT lasts TIMEOUT_CYCLES at most.
  assign w_timeout = (r_state == ST_WAIT) && !(|cl_finished) &&
                     (r_wait_cnt == WCNT_W'(TIMEOUT_CYCLES - 1));
  assign err       = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_wait_cnt <= (r_state == ST_WAIT) ? r_wait_cnt + WCNT_W'(1) : '0;
      if (w_accept_job) begin
        r_err <= 1'b0;
      end else if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end
`else
  logic w_unused_timeout;

  assign w_timeout        = 1'b0;
  assign err              = 1'b0;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  // NOTE: every output and the next state get a default first, so no path
  // through the case can leave a value unassigned and infer a latch.
  always_comb begin
    w_next    = r_state;
    job_ready = 1'b0;
    rd_en     = 1'b0;
    cl_start  = 1'b0;
    busy      = (r_state != ST_IDLE);
    done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        job_ready = 1'b1;
        if (job_valid) w_next = (job_tiles == '0) ? ST_DONE : ST_FETCH;
      end
      ST_FETCH: begin
        rd_en  = 1'b1;
        w_next = ST_LOAD;
      end
      ST_LOAD:  if (rd_valid) w_next = ST_START;
      ST_START: begin
        cl_start = 1'b1;
        w_next   = ST_WAIT;
      end
      ST_WAIT: begin
        if (|cl_finished)   w_next = ST_DRAIN;
        else if (w_timeout) w_next = ST_DONE;
      end
      ST_DRAIN: if (w_drain_last) w_next = w_last_tile ? ST_DONE : ST_FETCH;
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_tile      <= '0;
      r_tiles     <= '0;
      r_cl_data   <= '0;
      r_cl_filter <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept_job) begin
        r_tile  <= '0;
        r_tiles <= job_tiles;
      end else if (w_drain_last && !w_last_tile) begin
        r_tile <= r_tile + TILE_W'(1);
      end
      // Operands stay on the cluster inputs until the next tile's load.
      if ((r_state == ST_LOAD) && rd_valid) begin
        r_cl_data   <= rd_data;
        r_cl_filter <= rd_filter;
      end
    end
  end

  assign rd_addr   = r_tile;
  assign cl_data   = r_cl_data;
  assign cl_filter = r_cl_filter;
  assign res_tile  = r_tile;

  cluster_result_drain #(
    .ACC_WIDTH(ACC_WIDTH)
  ) u_drain (
    .clk          (clk),
    .rst          (rst),
    .i_capture    (w_capture),
    .i_cl_out     (cl_out),
    .i_active     (w_drain_active),
    .i_res_ready  (res_ready),
    .o_res_valid  (res_valid),
    .o_res_data   (res_data),
    .o_res_lane   (res_lane),
    .o_last_accept(w_drain_last)
  );

endmodule

// File: tb/tb_cluster_sequencer.sv
// Self-checking bench for cluster_sequencer: table-driven jobs, hand-written
// reset/timeout sequences and randomized jobs against a transaction-level model.
module tb_cluster_sequencer;

  localparam int IN_WIDTH  = 5;
  localparam int W_WIDTH   = 8;
  localparam int ACC_WIDTH = 16;
  localparam int TILE_W    = 8;
  localparam int LANES     = 6;

  bit clk = 1'b0;
  logic rst = 1'b1;
  logic job_valid = 1'b0;
  logic [TILE_W-1:0] job_tiles = '0;
  logic job_ready;
  logic rd_en;
  logic [TILE_W-1:0] rd_addr;
  logic rd_valid = 1'b0;
  logic [LANES*IN_WIDTH-1:0] rd_data = '0;
  logic [3*W_WIDTH-1:0] rd_filter = '0;
  logic cl_start;
  logic [LANES*IN_WIDTH-1:0] cl_data;
  logic [3*W_WIDTH-1:0] cl_filter;
  logic [LANES-1:0] cl_finished = '0;
  logic [LANES*ACC_WIDTH-1:0] cl_out = '0;
  logic res_valid;
  logic res_ready = 1'b0;
  logic [ACC_WIDTH-1:0] res_data;
  logic [2:0] res_lane;
  logic [TILE_W-1:0] res_tile;
  logic busy, done, err;

  cluster_sequencer dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready), .job_tiles(job_tiles),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_filter(rd_filter),
    .cl_start(cl_start), .cl_data(cl_data), .cl_filter(cl_filter),
    .cl_finished(cl_finished), .cl_out(cl_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_lane(res_lane), .res_tile(res_tile),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Responder configuration (written by the stimulus process only).
  int cfg_rd_dly   = 0;
  int cfg_fin_dly  = 0;   // -1: cluster never finishes
  int cfg_rmode    = 0;   // 0 ready always, 1 toggle, 2 random
  bit cfg_fixed    = 1'b0;
  bit cfg_noise    = 1'b0;
  int cfg_rst_lane = -1;
  int rst_req      = 0;

  // Reference model state (written by the monitor process only).
  typedef struct { logic [LANES*IN_WIDTH-1:0] d; logic [3*W_WIDTH-1:0] f; } op_t;
  typedef struct { logic [ACC_WIDTH-1:0] v; int lane; int tile; } beat_t;
  op_t   q_op[$];
  beat_t q_res[$];
  int rst_ack = 0, rst_count = 0;
  int rd_cnt = -1, fin_cnt = -1;
  bit rphase = 1'b0, prev_busy = 1'b0, held = 1'b0;
  int exp_addr = 0, fin_tile = 0, n_rd = 0, n_st = 0, n_res = 0, n_done = 0;
  logic [ACC_WIDTH-1:0] h_data;
  logic [2:0] h_lane;
  logic [TILE_W-1:0] h_tile;

  localparam logic [LANES*ACC_WIDTH-1:0] FIXED_OUT =
    {16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};

  always @(negedge clk) begin
    if (rst) begin
      check("rst_busy", busy, 0);
      check("rst_job_ready", job_ready, 1);
      check("rst_rd_en", rd_en, 0);
      check("rst_rd_addr", rd_addr, 0);
      check("rst_cl_start", cl_start, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_cl_data", cl_data, 0);
      check("rst_cl_filter", cl_filter, 0);
      check("rst_res_data", res_data, 0);
      check("rst_res_lane", res_lane, 0);
      check("rst_res_tile", res_tile, 0);
      rst = 1'b0;
      rd_cnt = -1;
      fin_cnt = -1;
      q_op.delete();
      q_res.delete();
      held = 1'b0;
      prev_busy = 1'b0;
      rst_count++;
    end else if ((rst_req != rst_ack) ||
                 (cfg_rst_lane >= 0 && res_valid && int'(res_lane) == cfg_rst_lane)) begin
      rst = 1'b1;
      rst_ack = rst_req;
      rd_valid = 1'b0;
      cl_finished = '0;
      res_ready = 1'b0;
    end else begin
      if (busy && !prev_busy) begin
        exp_addr = 0; fin_tile = 0; n_rd = 0; n_st = 0; n_res = 0; n_done = 0;
      end
      prev_busy = busy;

      case (cfg_rmode)
        0:       res_ready = 1'b1;
        1:       begin rphase = !rphase; res_ready = rphase; end
        default: res_ready = 1'($urandom_range(0, 1));
      endcase

      if (rd_en) begin
        n_rd++;
        check("rd_addr", rd_addr, exp_addr);
        exp_addr++;
      end
      if (cl_start) begin
        n_st++;
        check("op_outstanding", q_op.size(), 1);
        if (q_op.size() > 0) begin
          op_t o;
          o = q_op.pop_front();
          check("cl_data", cl_data, o.d);
          check("cl_filter", cl_filter, o.f);
        end
      end
      if (done) n_done++;
      if (res_valid) begin
        if (held) begin
          check("hold_data", res_data, h_data);
          check("hold_lane", res_lane, h_lane);
          check("hold_tile", res_tile, h_tile);
        end
        if (res_ready) begin
          n_res++;
          held = 1'b0;
          check("res_expected", q_res.size() != 0, 1);
          if (q_res.size() > 0) begin
            beat_t b;
            b = q_res.pop_front();
            check("res_data", res_data, b.v);
            check("res_lane", res_lane, b.lane);
            check("res_tile", res_tile, b.tile);
          end
        end else begin
          held = 1'b1;
          h_data = res_data; h_lane = res_lane; h_tile = res_tile;
        end
      end else begin
        held = 1'b0;
      end

      rd_valid = 1'b0;
      if (rd_cnt == 0) begin
        rd_valid = 1'b1;
        rd_data = 30'($urandom);
        rd_filter = 24'($urandom);
        q_op.push_back('{rd_data, rd_filter});
        rd_cnt = -1;
      end else if (rd_cnt > 0) begin
        rd_cnt--;
      end else if (cfg_noise && $urandom_range(0, 2) == 0) begin
        rd_valid = 1'b1;
        rd_data = 30'($urandom);
        rd_filter = 24'($urandom);
      end
      if (rd_en) rd_cnt = cfg_rd_dly;

      cl_finished = '0;
      if (fin_cnt == 0) begin
        cl_finished = 6'($urandom_range(1, 63));
        cl_out = cfg_fixed ? FIXED_OUT : {$urandom, $urandom, $urandom};
        for (int l = 0; l < LANES; l++) q_res.push_back('{cl_out[l*ACC_WIDTH +: ACC_WIDTH], l, fin_tile});
        fin_tile++;
        fin_cnt = -1;
      end else if (fin_cnt > 0) begin
        fin_cnt--;
      end else if (cfg_noise && $urandom_range(0, 2) == 0) begin
        cl_finished = 6'($urandom_range(1, 63));
        cl_out = {$urandom, $urandom, $urandom};
      end
      if (cl_start) fin_cnt = (cfg_fin_dly < 0) ? 1000000 : cfg_fin_dly;
    end
  end

  task automatic do_reset(input string tag);
    int base;
    base = rst_count;
    rst_req++;
    for (int i = 0; i < 10 && rst_count == base; i++) @(negedge clk);
    check({tag, "_reset_taken"}, rst_count != base, 1);
  endtask

  task automatic run_job(input string tag, input int tiles, input int exp_cycles,
                         input int exp_res, input bit exp_err, input bit poke);
    int cnt;
    bit seen;
    @(negedge clk);
    check({tag, "_ready_idle"}, job_ready, 1);
    job_valid = 1'b1;
    job_tiles = TILE_W'(tiles);
    @(negedge clk);
    job_valid = 1'b0;
    cnt = 1;
    seen = 1'b0;
    while (cnt < 3000) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (poke) begin
        check({tag, "_ready_busy"}, job_ready, 0);
        job_valid = 1'b1;
        job_tiles = TILE_W'($urandom_range(0, 255));
      end
      @(negedge clk);
      cnt++;
    end
    job_valid = 1'b0;
    check({tag, "_done_seen"}, seen, 1);
    if (!seen) begin
      do_reset(tag);
    end else begin
      if (exp_cycles > 0) check({tag, "_cycles"}, cnt + 1, exp_cycles);
      check({tag, "_err"}, err, exp_err);
      @(negedge clk);
      check({tag, "_done_pulse"}, done, 0);
      check({tag, "_idle_busy"}, busy, 0);
      check({tag, "_idle_ready"}, job_ready, 1);
      check({tag, "_rd_pulses"}, n_rd, (tiles == 0) ? 0 : (exp_res == 0 ? 1 : tiles));
      check({tag, "_starts"}, n_st, (tiles == 0) ? 0 : (exp_res == 0 ? 1 : tiles));
      check({tag, "_results"}, n_res, exp_res);
      check({tag, "_done_count"}, n_done, 1);
      check({tag, "_leftover"}, q_res.size(), 0);
    end
  endtask

  typedef struct {
    int tiles; int rd_dly; int fin_dly; int rmode;
    bit fixed; bit noise; bit poke; int exp_cycles;
  } vec_t;
  vec_t tbl[5];

  initial begin
    int base;
    tbl[0] = '{2, 0, 0, 0, 1'b0, 1'b0, 1'b0, 22};  // back-to-back tiles
    tbl[1] = '{0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 2};   // empty job
    tbl[2] = '{1, 0, 0, 0, 1'b0, 1'b1, 1'b0, 12};  // stray handshakes ignored
    tbl[3] = '{3, 1, 2, 1, 1'b1, 1'b0, 1'b1, 0};   // toggling ready, job poked while busy
    tbl[4] = '{2, 0, 0, 1, 1'b1, 1'b1, 1'b0, 0};   // lanes 1..6 under back-pressure

    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      cfg_rd_dly = tbl[i].rd_dly; cfg_fin_dly = tbl[i].fin_dly; cfg_rmode = tbl[i].rmode;
      cfg_fixed = tbl[i].fixed; cfg_noise = tbl[i].noise;
      run_job($sformatf("vec%0d", i), tbl[i].tiles, tbl[i].exp_cycles,
              6 * tbl[i].tiles, 1'b0, tbl[i].poke);
    end

    // Reset while lane 3 of the first tile is on the result port.
    cfg_rd_dly = 0; cfg_fin_dly = 0; cfg_rmode = 0; cfg_fixed = 1'b0; cfg_noise = 1'b0;
    cfg_rst_lane = 3;
    base = rst_count;
    @(negedge clk);
    job_valid = 1'b1;
    job_tiles = 8'd2;
    @(negedge clk);
    job_valid = 1'b0;
    for (int i = 0; i < 100 && rst_count == base; i++) @(negedge clk);
    cfg_rst_lane = -1;
    check("mid_drain_reset_taken", rst_count != base, 1);
    check("mid_drain_lanes_before_reset", n_res, 3);
    run_job("post_reset", 1, 12, 6, 1'b0, 1'b0);

`ifdef CLUSTER_SEQ_TIMEOUT_EN
    cfg_fin_dly = -1;
    run_job("timeout", 1, 69, 0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check("err_sticky", err, 1);
    cfg_fin_dly = 0;
    run_job("after_timeout", 1, 12, 6, 1'b0, 1'b0);
`else
    cfg_fin_dly = -1;
    @(negedge clk);
    job_valid = 1'b1;
    job_tiles = 8'd1;
    @(negedge clk);
    job_valid = 1'b0;
    repeat (150) @(negedge clk);
    check("stuck_wait_busy", busy, 1);
    check("stuck_wait_err", err, 0);
    check("stuck_wait_done", n_done, 0);
    check("stuck_wait_no_results", n_res, 0);
    cfg_fin_dly = 0;
    do_reset("stuck_wait");
`endif

    for (int j = 0; j < 10; j++) begin
      int t;
      cfg_rd_dly = $urandom_range(0, 3);
      cfg_fin_dly = $urandom_range(0, 3);
      cfg_rmode = $urandom_range(0, 2);
      cfg_fixed = 1'b0;
      cfg_noise = 1'b1;
      t = $urandom_range(1, 4);
      run_job($sformatf("rand%0d", j), t, 0, 6 * t, 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
